// File: rtl/apuracao_eliminacao_pkg.sv
// Shared constants, state codes and helpers for the
// vote / elimination datapath (apuracao_eliminacao).
package apuracao_pkg;

   localparam int N_JOGADORES_PADRAO = 5;
   localparam int MIN_VIVOS_PADRAO   = 2;

   typedef logic [2:0] id_t;

   localparam id_t NENHUM = 3'd7;

   localparam logic [2:0] OCIOSO       = 3'd0;
   localparam logic [2:0] NOITE_ESPERA = 3'd1;
   localparam logic [2:0] NOITE_FEITO  = 3'd2;
   localparam logic [2:0] VOTO_ESPERA  = 3'd3;
   localparam logic [2:0] VOTO_FEITO   = 3'd4;

   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) begin
         c = c + 4'(v[i]);
      end
      return c;
   endfunction

   function automatic logic [7:0] one_hot(input id_t id);
      return 8'b1 << id;
   endfunction

endpackage

// File: rtl/apuracao_eliminacao_detector_borda.sv
// Registered rising-edge detector: one pulse per 0->1
// transition of sinal, no repeat while it is held high.
module detector_borda (
   input  logic clock,
   input  logic reset,
   input  logic sinal,
   output logic pulso
);

   logic sinal_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sinal_q <= 1'b0;
      end else begin
         sinal_q <= sinal;
      end
   end

   assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/apuracao_eliminacao.sv
// Alive mask, night kill and day vote datapath for the game FSM.
// Optional: define VOTO_NULO_EN to accept alvo=7 as an abstention.
module apuracao_eliminacao
   import apuracao_pkg::*;
#(
   parameter int N_JOGADORES = N_JOGADORES_PADRAO,
   parameter int MIN_VIVOS   = MIN_VIVOS_PADRAO
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   rst_global,
   input  logic [2:0]             jogador_atual,
   input  logic [2:0]             lobo_id,
   input  logic [2:0]             alvo,
   input  logic                   confirma,
   input  logic                   processar_acao,
   input  logic                   avaliar_eliminacao,
   input  logic                   votacao,
   input  logic                   morra,
   output logic                   jogou,
   output logic                   votou,
   output logic                   acertou,
   output logic                   jogador_vivo,
   output logic                   sinal_lobo_ganhou,
   output logic [N_JOGADORES-1:0] vivos,
   output logic [2:0]             db_estado
);

   logic [2:0]             estado;
   logic [2:0]             estado_nxt;
   logic [N_JOGADORES-1:0] vivos_q;
   id_t                    alvo_noite;
   id_t                    voto;

   logic       conf_p;
   logic [7:0] vivos_ext;
   logic [7:0] mascara_morte;
   logic       alvo_valido;
   logic       e_lobo;
   logic       voto_nulo;
   logic       aceita_noite;
   logic       aceita_voto;
   logic       captura_noite;
   logic       captura_voto;

   detector_borda u_borda (
      .clock (clock),
      .reset (reset),
      .sinal (confirma),
      .pulso (conf_p)
   );

   // Zero-extended mask: out-of-range ids read as dead.
   always_comb begin
      vivos_ext = '0;
      vivos_ext[N_JOGADORES-1:0] = vivos_q;
   end

   assign alvo_valido = (int'(alvo) < N_JOGADORES)
                      && vivos_ext[alvo];
   assign e_lobo = (jogador_atual == lobo_id);

`ifdef VOTO_NULO_EN
   assign voto_nulo = (alvo == NENHUM);
`else
   assign voto_nulo = 1'b0;
`endif

   assign aceita_noite = conf_p
      && (!e_lobo || (alvo_valido && (alvo != lobo_id)));
   assign aceita_voto = conf_p && (alvo_valido || voto_nulo);

   assign captura_noite = (estado == NOITE_ESPERA)
      && processar_acao && e_lobo && aceita_noite;
   assign captura_voto = (estado == VOTO_ESPERA)
      && votacao && aceita_voto;

   always_comb begin
      estado_nxt = estado;
      unique case (estado)
         OCIOSO: begin
            if (processar_acao) begin
               estado_nxt = NOITE_ESPERA;
            end else if (votacao) begin
               estado_nxt = VOTO_ESPERA;
            end
         end
         NOITE_ESPERA: begin
            if (!processar_acao) begin
               estado_nxt = OCIOSO;
            end else if (aceita_noite) begin
               estado_nxt = NOITE_FEITO;
            end
         end
         NOITE_FEITO: begin
            if (!processar_acao) begin
               estado_nxt = OCIOSO;
            end
         end
         VOTO_ESPERA: begin
            if (!votacao) begin
               estado_nxt = OCIOSO;
            end else if (aceita_voto) begin
               estado_nxt = VOTO_FEITO;
            end
         end
         VOTO_FEITO: begin
            if (!votacao) begin
               estado_nxt = OCIOSO;
            end
         end
         default: estado_nxt = OCIOSO;
      endcase
   end

   // Night kill and day elimination may land in the same cycle.
   always_comb begin
      mascara_morte = '0;
      if (avaliar_eliminacao && (alvo_noite != NENHUM)) begin
         mascara_morte = mascara_morte | one_hot(alvo_noite);
      end
      if (morra && (voto != NENHUM)) begin
         mascara_morte = mascara_morte | one_hot(voto);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         vivos_q    <= '1;
         alvo_noite <= NENHUM;
         voto       <= NENHUM;
      end else if (rst_global) begin
         estado     <= OCIOSO;
         vivos_q    <= '1;
         alvo_noite <= NENHUM;
         voto       <= NENHUM;
      end else begin
         estado  <= estado_nxt;
         vivos_q <= vivos_q & ~mascara_morte[N_JOGADORES-1:0];
         if (avaliar_eliminacao) begin
            alvo_noite <= NENHUM;
         end
         if (morra) begin
            voto <= NENHUM;
         end
         // A fresh capture overrides the consume-and-clear above.
         if (captura_noite) begin
            alvo_noite <= alvo;
         end
         if (captura_voto) begin
            voto <= alvo;
         end
      end
   end

   assign jogou     = (estado == NOITE_FEITO);
   assign votou     = (estado == VOTO_FEITO);
   assign acertou   = (voto != NENHUM) && (voto == lobo_id);
   assign vivos     = vivos_q;
   assign db_estado = estado;

   assign jogador_vivo = vivos_ext[jogador_atual];
   assign sinal_lobo_ganhou = vivos_ext[lobo_id]
      && (popcount(vivos_ext) <= 4'(MIN_VIVOS));

endmodule

// File: tb/tb_apuracao_eliminacao.sv
// Bench for apuracao_eliminacao: directed game script plus
// randomized strobes against a round-level behavioural model.
module tb_apuracao_eliminacao;

   localparam int N    = 5;
   localparam int MINV = 2;

   logic         clock = 1'b0;
   logic         reset;
   logic         rst_global;
   logic [2:0]   jogador_atual;
   logic [2:0]   lobo_id;
   logic [2:0]   alvo;
   logic         confirma;
   logic         processar_acao;
   logic         avaliar_eliminacao;
   logic         votacao;
   logic         morra;
   logic         jogou;
   logic         votou;
   logic         acertou;
   logic         jogador_vivo;
   logic         sinal_lobo_ganhou;
   logic [N-1:0] vivos;
   logic [2:0]   db_estado;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   apuracao_eliminacao #(
      .N_JOGADORES (N),
      .MIN_VIVOS   (MINV)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .rst_global         (rst_global),
      .jogador_atual      (jogador_atual),
      .lobo_id            (lobo_id),
      .alvo               (alvo),
      .confirma           (confirma),
      .processar_acao     (processar_acao),
      .avaliar_eliminacao (avaliar_eliminacao),
      .votacao            (votacao),
      .morra              (morra),
      .jogou              (jogou),
      .votou              (votou),
      .acertou            (acertou),
      .jogador_vivo       (jogador_vivo),
      .sinal_lobo_ganhou  (sinal_lobo_ganhou),
      .vivos              (vivos),
      .db_estado          (db_estado)
   );

   always #5 clock = ~clock;

   // Model: who is alive, pending night target, latched vote,
   // which window we are in (0 none, 1 night, 2 day) and
   // whether this window's action was already taken.
   bit m_alive[8];
   int m_noite;
   int m_voto;
   int m_janela;
   bit m_feito;
   bit m_prev;

   task automatic m_limpa();
      for (int i = 0; i < 8; i++) m_alive[i] = (i < N);
      m_noite  = 7;
      m_voto   = 7;
      m_janela = 0;
      m_feito  = 1'b0;
   endtask

   function automatic bit m_valido(input int id);
      return (id < N) && m_alive[id];
   endfunction

   function automatic int m_vivos();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_alive[i]) v |= (1 << i);
      return v;
   endfunction

   function automatic int m_conta();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_alive[i]);
      return c;
   endfunction

   function automatic int m_estado();
      if (m_janela == 1) return m_feito ? 2 : 1;
      if (m_janela == 2) return m_feito ? 4 : 3;
      return 0;
   endfunction

   always @(posedge clock) begin
      bit cp;
      bit ok;
      int vn;
      int vv;
      if (reset) begin
         m_limpa();
         m_prev = 1'b0;
      end else begin
         cp = confirma && !m_prev;
         m_prev = confirma;
         if (rst_global) begin
            m_limpa();
         end else begin
            ok = m_valido(int'(alvo));
            vn = m_noite;
            vv = m_voto;
            if (avaliar_eliminacao) begin
               if (vn < N) m_alive[vn] = 1'b0;
               m_noite = 7;
            end
            if (morra) begin
               if (vv < N) m_alive[vv] = 1'b0;
               m_voto = 7;
            end
            if (m_janela == 0) begin
               m_feito = 1'b0;
               if (processar_acao) m_janela = 1;
               else if (votacao) m_janela = 2;
            end else if (m_janela == 1) begin
               if (!processar_acao) begin
                  m_janela = 0;
               end else if (!m_feito && cp) begin
                  if (jogador_atual != lobo_id) begin
                     m_feito = 1'b1;
                  end else if (ok && alvo != lobo_id) begin
                     m_noite = int'(alvo);
                     m_feito = 1'b1;
                  end
               end
            end else begin
               if (!votacao) begin
                  m_janela = 0;
               end else if (!m_feito && cp) begin
                  if (ok) begin
                     m_voto  = int'(alvo);
                     m_feito = 1'b1;
                  end
`ifdef VOTO_NULO_EN
                  else if (alvo == 3'd7) begin
                     m_voto  = 7;
                     m_feito = 1'b1;
                  end
`endif
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      int ja;
      if (chk_en && !reset) begin
         ja = int'(jogador_atual);
         chk("vivos", int'(vivos), m_vivos());
         chk("jogou", int'(jogou),
             int'(m_janela == 1 && m_feito));
         chk("votou", int'(votou),
             int'(m_janela == 2 && m_feito));
         chk("acertou", int'(acertou),
             int'(m_voto == int'(lobo_id)));
         chk("jogador_vivo", int'(jogador_vivo),
             int'(ja < N && m_alive[ja]));
         chk("sinal_lobo_ganhou", int'(sinal_lobo_ganhou),
             int'(m_alive[lobo_id] && m_conta() <= MINV));
         chk("db_estado", int'(db_estado), m_estado());
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic pulso_conf();
      confirma = 1'b1;
      step();
      confirma = 1'b0;
   endtask

   initial begin
      int r;
      reset = 1'b1;
      rst_global = 1'b0;
      confirma = 1'b0;
      processar_acao = 1'b0;
      avaliar_eliminacao = 1'b0;
      votacao = 1'b0;
      morra = 1'b0;
      jogador_atual = 3'd0;
      lobo_id = 3'd2;
      alvo = 3'd0;
      step();
      step();
      reset = 1'b0;
      step();
      chk_en = 1'b1;

      chk("rst_vivos", int'(vivos), 'h1f);
      chk("rst_sinal", int'(sinal_lobo_ganhou), 0);
      chk("rst_jogou", int'(jogou), 0);
      chk("rst_votou", int'(votou), 0);
      chk("rst_estado", int'(db_estado), 0);

      // Night: wolf tries itself, then kills 4.
      jogador_atual = 3'd2;
      processar_acao = 1'b1;
      step();
      alvo = 3'd2;
      pulso_conf();
      step();
      chk("lobo_self_jogou", int'(jogou), 0);
      chk("lobo_self_estado", int'(db_estado), 1);
      alvo = 3'd4;
      pulso_conf();
      chk("lobo_ok_jogou", int'(jogou), 1);
      chk("lobo_ok_estado", int'(db_estado), 2);
      processar_acao = 1'b0;
      step();
      chk("jogou_cai", int'(jogou), 0);
      avaliar_eliminacao = 1'b1;
      step();
      avaliar_eliminacao = 1'b0;
      chk("noite1_vivos", int'(vivos), 'h0f);

      // Day: vote for dead 4 ignored, vote 1 kept.
      votacao = 1'b1;
      step();
      alvo = 3'd4;
      pulso_conf();
      step();
      chk("voto_morto", int'(votou), 0);
      alvo = 3'd1;
      pulso_conf();
      chk("voto1_votou", int'(votou), 1);
      chk("voto1_acertou", int'(acertou), 0);
      votacao = 1'b0;
      step();
      morra = 1'b1;
      step();
      morra = 1'b0;
      chk("dia1_vivos", int'(vivos), 'h0d);
      chk("dia1_sinal", int'(sinal_lobo_ganhou), 0);

      // Night 2: wolf kills 0 -> wolf wins.
      processar_acao = 1'b1;
      step();
      alvo = 3'd0;
      pulso_conf();
      processar_acao = 1'b0;
      step();
      avaliar_eliminacao = 1'b1;
      step();
      avaliar_eliminacao = 1'b0;
      chk("noite2_vivos", int'(vivos), 'h0c);
      chk("noite2_sinal", int'(sinal_lobo_ganhou), 1);

      // Day 2: vote wolf, hold confirm across two windows.
      votacao = 1'b1;
      step();
      alvo = 3'd2;
      confirma = 1'b1;
      step();
      chk("voto2_votou", int'(votou), 1);
      chk("voto2_acertou", int'(acertou), 1);
      votacao = 1'b0;
      step();
      votacao = 1'b1;
      step();
      step();
      step();
      chk("segurado_votou", int'(votou), 0);
      chk("segurado_estado", int'(db_estado), 3);
      chk("segurado_acertou", int'(acertou), 1);
      confirma = 1'b0;
      step();

      rst_global = 1'b1;
      step();
      rst_global = 1'b0;
      chk("rstg_estado", int'(db_estado), 0);
      chk("rstg_vivos", int'(vivos), 'h1f);
      chk("rstg_acertou", int'(acertou), 0);
      votacao = 1'b0;
      step();

      jogador_atual = 3'd6;
      #1;
      chk("vivo_fora", int'(jogador_vivo), 0);
      jogador_atual = 3'd3;
      #1;
      chk("vivo_3", int'(jogador_vivo), 1);

      votacao = 1'b1;
      step();
      alvo = 3'd7;
      pulso_conf();
`ifdef VOTO_NULO_EN
      chk("nulo_votou", int'(votou), 1);
      chk("nulo_acertou", int'(acertou), 0);
`else
      chk("nulo_votou", int'(votou), 0);
      chk("nulo_estado", int'(db_estado), 3);
`endif
      votacao = 1'b0;
      step();
      morra = 1'b1;
      step();
      morra = 1'b0;
      chk("nulo_vivos", int'(vivos), 'h1f);

      for (int k = 0; k < 4000; k++) begin
         reset = 1'b0;
         rst_global = 1'b0;
         avaliar_eliminacao = 1'b0;
         morra = 1'b0;
         r = int'($urandom_range(0, 999));
         if (r < 2) begin
            reset = 1'b1;
            lobo_id = 3'($urandom_range(0, N - 1));
         end else if (r < 8) begin
            rst_global = 1'b1;
         end
         if ($urandom_range(0, 7) == 0)
            processar_acao = ~processar_acao;
         if ($urandom_range(0, 7) == 0) votacao = ~votacao;
         if ($urandom_range(0, 2) == 0) confirma = ~confirma;
         if ($urandom_range(0, 3) == 0)
            alvo = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0)
            jogador_atual = ($urandom_range(0, 1) == 1)
               ? lobo_id : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 11) == 0) avaliar_eliminacao = 1'b1;
         if ($urandom_range(0, 11) == 0) morra = 1'b1;
         step();
      end

      reset = 1'b0;
      rst_global = 1'b0;
      avaliar_eliminacao = 1'b0;
      morra = 1'b0;
      step();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/apuracao_eliminacao.md
Name: apuracao_eliminacao

Overview:
Datapath responder to the game control unit. Consumes its per-state strobes (processar_acao, avaliar_eliminacao, votacao, morra, rst_global) and returns the status flags it branches on (jogou, votou, acertou, jogador_vivo, sinal_lobo_ganhou). Holds the alive mask, the wolf's pending night kill and the day vote. Captures target selections from the player switch and confirm button.

Parameters:
N_JOGADORES, 5, number of players; valid ids are 0..N_JOGADORES-1 (max 7).
MIN_VIVOS, 2, wolf wins when the alive count, wolf included, is at most this value.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; forces all state to reset values
rst_global  in  1  synchronous clear from the control unit; same effect as reset
jogador_atual  in  3  player-counter value (current night turn)
lobo_id  in  3  wolf player id, stable after seed storage
alvo  in  3  target id from switches
confirma  in  1  confirm button, already synchronised; level
processar_acao  in  1  night-turn window
avaliar_eliminacao  in  1  one-cycle strobe: apply night kill
votacao  in  1  day-vote window
morra  in  1  one-cycle strobe: eliminate voted player
jogou  out  1  current night turn finished; held until processar_acao falls
votou  out  1  valid vote latched; held until votacao falls
acertou  out  1  latched vote equals lobo_id
jogador_vivo  out  1  vivos[jogador_atual]; 0 if id out of range
sinal_lobo_ganhou  out  1  popcount(vivos) <= MIN_VIVOS while the wolf is alive
vivos  out  N_JOGADORES  alive mask
db_estado  out  3  FSM state code

Behaviour:
- Reset or rst_global: vivos = all ones; alvo_noite = NENHUM (3'd7); voto = NENHUM; jogou = votou = acertou = 0; state = OCIOSO.
- confirma is rising-edge detected. Only a 0->1 edge counts as a confirm pulse (conf_p); holding the button does not repeat.
- Target validity: id < N_JOGADORES and vivos[id] = 1.
- FSM states: OCIOSO(0), NOITE_ESPERA(1), NOITE_FEITO(2), VOTO_ESPERA(3), VOTO_FEITO(4).
- OCIOSO:
  - processar_acao -> NOITE_ESPERA.
  - votacao -> VOTO_ESPERA.
  - If both are high, processar_acao has priority.
- NOITE_ESPERA:
  - On conf_p with jogador_atual != lobo_id -> NOITE_FEITO.
  - On conf_p with jogador_atual == lobo_id: accepted only if alvo is valid and alvo != lobo_id. Then alvo_noite <= alvo and go to NOITE_FEITO.
  - An invalid wolf confirm is ignored; stay in NOITE_ESPERA.
  - processar_acao falls -> OCIOSO.
- NOITE_FEITO: jogou = 1 (registered; asserted the cycle after the accepted conf_p). processar_acao low -> OCIOSO; jogou clears on that transition.
- VOTO_ESPERA:
  - On conf_p with a valid alvo: voto <= alvo, go to VOTO_FEITO.
  - An invalid confirm is ignored.
  - votacao falls -> OCIOSO; voto is retained.
- VOTO_FEITO: votou = 1. votacao low -> OCIOSO; votou clears, voto kept for PROCESSA_VOTO/morra.
- acertou: combinational, (voto == lobo_id).
- avaliar_eliminacao:
  - If alvo_noite != NENHUM, clear vivos[alvo_noite].
  - Then alvo_noite <= NENHUM.
  - Applies in any state.
- morra:
  - If voto != NENHUM, clear vivos[voto].
  - Then voto <= NENHUM.
- Simultaneous avaliar_eliminacao and morra: apply both clears in the same cycle.
- sinal_lobo_ganhou: combinational from the registered vivos. Valid one cycle after avaliar_eliminacao/morra, in time for the CHECAR_LOBO_GANHOU_* state.
- A kill of an already-dead player is a no-op.
- Ids >= N_JOGADORES are never written.

Optional Feature:
VOTO_NULO_EN
- Defined: in VOTO_ESPERA, conf_p with alvo == 3'd7 is accepted as an abstention. voto = NENHUM, votou = 1, acertou = 0, and the following morra eliminates nobody.
- Undefined: alvo == 3'd7 is invalid and ignored like any other out-of-range id.

Decomposition:
- Package apuracao_pkg: N_JOGADORES default, NENHUM = 3'd7, FSM state encodings, popcount function.
- One sub-module: detector_borda (clock, reset, sinal -> pulso), a registered rising-edge detector used for confirma.

Test Plan:
- Reset, lobo_id=2, all alive: vivos=5'b11111, sinal_lobo_ganhou=0, jogou=votou=0, db_estado=0.
- Night, jogador_atual=2 (wolf): alvo=2 then confirm -> ignored. alvo=4, confirm -> jogou=1. After avaliar_eliminacao pulse -> vivos=5'b01111.
- Day vote: alvo=4 (dead) confirm -> ignored. alvo=1 confirm -> votou=1, acertou=0. After morra -> vivos=5'b01101, sinal_lobo_ganhou=0 (3 alive > 2).
- Next night, wolf kills 0, avaliar_eliminacao: vivos=5'b01100 -> sinal_lobo_ganhou=1.
- Day vote alvo=2 -> acertou=1. Holding confirma across two votacao windows yields only one latched vote.
- rst_global mid-VOTO_ESPERA -> state 0, vivos all ones, voto=NENHUM. With VOTO_NULO_EN, alvo=7 confirm -> votou=1, morra leaves vivos unchanged.
